// File: rtl/line_cache_if.sv
// line_cache_if: processor load/store port and single-word memory port of
// the line cache, bundled into one interface.
//   slave  : the cache side (takes requests, drives load data / memory bus)
//   master : the processor + memory side (drives requests, refill data, ack)
// Processor side: pAddr, pDataOut, readRequest, writeRequest -> cache;
//                 pDataIn, busyClock <- cache.
// Memory side:    mAddr, mDataOut, mRead, mWrite <- cache;
//                 mDataIn, mAck -> cache.
interface line_cache_if #(
  parameter int DWS = 16,
  parameter int MAS = 10
);
  logic [MAS-1:0] pAddr;
  logic [DWS-1:0] pDataOut;
  logic [DWS-1:0] pDataIn;
  logic           readRequest;
  logic           writeRequest;
  logic           busyClock;
  logic [MAS-1:0] mAddr;
  logic [DWS-1:0] mDataOut;
  logic [DWS-1:0] mDataIn;
  logic           mRead;
  logic           mWrite;
  logic           mAck;

  modport slave (
    input  pAddr, pDataOut, readRequest, writeRequest, mDataIn, mAck,
    output pDataIn, busyClock, mAddr, mDataOut, mRead, mWrite
  );

  modport master (
    output pAddr, pDataOut, readRequest, writeRequest, mDataIn, mAck,
    input  pDataIn, busyClock, mAddr, mDataOut, mRead, mWrite
  );
endinterface

// File: rtl/line_cache.sv
// line_cache: direct-mapped, write-back, write-allocate cache with
// 2^WPLB-word lines between a processor load/store port and a single-word
// handshaked memory port. Hits complete combinationally; a miss stalls via
// busyClock, writes back a dirty victim word by word, then refills the line.
// Ports:
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-low
//   bus        : line_cache_if.slave (processor and memory signals)
//   hitCount   : 16-bit hit counter    (only with CACHE_STATS_EN)
//   missCount  : 16-bit miss counter   (only with CACHE_STATS_EN)
// Optional feature macro: CACHE_STATS_EN adds the hit/miss counters.
// Address split: {tag, index, offset} = pAddr, tag width MAS-CLAS-WPLB.
module line_cache #(
  parameter int DWS  = 16,
  parameter int MAS  = 10,
  parameter int CLAS = 5,
  parameter int WPLB = 2
) (
  input  logic            clk,
  input  logic            reset,
  line_cache_if.slave     bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]     hitCount,
  output logic [15:0]     missCount
`endif
);
  localparam int TW    = MAS - CLAS - WPLB;
  localparam int LINES = 1 << CLAS;
  localparam int WPL   = 1 << WPLB;

  generate
    if (TW < 1) begin : g_tw_chk
      $error("line_cache: tag width MAS-CLAS-WPLB must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WBACK, FILL} state_e;

  // line storage
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [DWS-1:0]   data_q [LINES][WPL];

  // miss bookkeeping
  state_e           state_q, state_d;
  logic [WPLB-1:0]  wc_q, wc_d;
  logic [TW-1:0]    mtag_q;
  logic [CLAS-1:0]  midx_q;

  // address split
  logic [TW-1:0]    p_tag;
  logic [CLAS-1:0]  p_idx;
  logic [WPLB-1:0]  p_off;
  assign {p_tag, p_idx, p_off} = bus.pAddr;

  logic req, hit, last_word;
  logic hit_we, miss_start, wb_done, fill_we, fill_done;

  assign req       = bus.readRequest | bus.writeRequest;
  assign hit       = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign last_word = &wc_q;

  assign bus.pDataIn = data_q[p_idx][p_off];

  always_comb begin
    state_d       = state_q;
    wc_d          = wc_q;
    bus.busyClock = 1'b0;
    bus.mRead     = 1'b0;
    bus.mWrite    = 1'b0;
    bus.mAddr     = '0;
    bus.mDataOut  = '0;
    hit_we        = 1'b0;
    miss_start    = 1'b0;
    wb_done       = 1'b0;
    fill_we       = 1'b0;
    fill_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // a write wins when both requests are high
            hit_we = bus.writeRequest;
          end else begin
            bus.busyClock = 1'b1;
            miss_start    = 1'b1;
            wc_d          = '0;
            state_d       = (valid_q[p_idx] && dirty_q[p_idx]) ? WBACK : FILL;
          end
        end
      end
      WBACK: begin
        bus.busyClock = 1'b1;
        bus.mWrite    = 1'b1;
        // victim still owns the line, so its tag is the one in the array
        bus.mAddr     = {tag_q[midx_q], midx_q, wc_q};
        bus.mDataOut  = data_q[midx_q][wc_q];
        if (bus.mAck) begin
          wc_d = wc_q + 1'b1;  // wraps to 0 after the last word
          if (last_word) begin
            wb_done = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        bus.busyClock = 1'b1;
        bus.mRead     = 1'b1;
        bus.mAddr     = {mtag_q, midx_q, wc_q};
        if (bus.mAck) begin
          fill_we = 1'b1;
          wc_d    = wc_q + 1'b1;
          if (last_word) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // while reset is held the memory port and stall are quiet and no
    // storage is touched, so an in-flight transfer is simply dropped
    if (!reset) begin
      bus.busyClock = 1'b0;
      bus.mRead     = 1'b0;
      bus.mWrite    = 1'b0;
      bus.mAddr     = '0;
      bus.mDataOut  = '0;
      hit_we        = 1'b0;
      miss_start    = 1'b0;
      wb_done       = 1'b0;
      fill_we       = 1'b0;
      fill_done     = 1'b0;
    end
  end

  // control state with reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wc_q    <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      if (hit_we)    dirty_q[p_idx]  <= 1'b1;
      if (wb_done)   dirty_q[midx_q] <= 1'b0;
      // valid only rises once the whole line is in, so an abandoned
      // refill leaves the line invalid
      if (fill_done) valid_q[midx_q] <= 1'b1;
    end
  end

  // data, tags and miss latches: qualified by valid/state, no reset needed
  always_ff @(posedge clk) begin
    if (miss_start) begin
      mtag_q <= p_tag;
      midx_q <= p_idx;
    end
    if (hit_we)    data_q[p_idx][p_off] <= bus.pDataOut;
    if (fill_we)   data_q[midx_q][wc_q] <= bus.mDataIn;
    if (fill_done) tag_q[midx_q]        <= mtag_q;
  end

`ifdef CACHE_STATS_EN
  logic        pend_q;
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        idle_hit;

  assign idle_hit = (state_q == IDLE) && req && hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (miss_start) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
        pend_q     <= 1'b1;
      end
      // the hit that completes a miss is part of that miss, not a new hit
      if (idle_hit) begin
        if (pend_q) pend_q    <= 1'b0;
        else        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif
endmodule

// File: tb/tb_line_cache.sv
module tb_line_cache;
  logic clk;
  logic reset;
`ifdef CACHE_STATS_EN
  logic [15:0] hitCount, missCount;
`endif

  line_cache_if #(.DWS(16), .MAS(10)) bus ();

  line_cache #(.DWS(16), .MAS(10), .CLAS(5), .WPLB(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hitCount  (hitCount),
    .missCount (missCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] data;
  } mem_t;

  mem_t        exp_mem[$];
  logic [15:0] exp_rd[$];
  int checks = 0;
  int errors = 0;
  int mem_delay = 0;
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory: word content equals its address; ack after mem_delay wait cycles
  assign bus.mDataIn = {6'b0, bus.mAddr};

  always @(negedge clk) begin
    if (reset && (bus.mRead || bus.mWrite)) begin
      if (ack_cnt >= mem_delay) begin
        bus.mAck = 1'b1;
        ack_cnt  = 0;
      end else begin
        bus.mAck = 1'b0;
        ack_cnt++;
      end
    end else begin
      bus.mAck = 1'b0;
      ack_cnt  = 0;
    end
  end

  // monitor: memory transfers and completed loads against the queues
  always begin
    mem_t e;
    @(negedge clk);
    #1;
    if (bus.mRead || bus.mWrite) begin
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected", {21'b0, bus.mWrite, bus.mAddr}, 32'hffff_ffff);
      end else begin
        e = exp_mem[0];
        chk("mem_dir", {31'b0, bus.mWrite}, {31'b0, e.wr});
        chk("mem_addr", {22'b0, bus.mAddr}, {22'b0, e.addr});
        if (e.wr) chk("mem_wdata", {16'b0, bus.mDataOut}, {16'b0, e.data});
        if (bus.mAck) void'(exp_mem.pop_front());
      end
    end else begin
      chk("mAddr_idle", {22'b0, bus.mAddr}, 32'h0);
    end
    if (reset && bus.readRequest && !bus.writeRequest && !bus.busyClock) begin
      if (exp_rd.size() == 0)
        chk("rd_unexpected", {16'b0, bus.pDataIn}, 32'hffff_ffff);
      else
        chk("rd_data", {16'b0, bus.pDataIn}, {16'b0, exp_rd.pop_front()});
    end
  end

  task automatic push_fill(input logic [9:0] base);
    for (int i = 0; i < 4; i++) exp_mem.push_back({1'b0, base + 10'(i), 16'h0});
  endtask

  task automatic push_wb(input logic [9:0] base, input logic [15:0] w0, w1, w2, w3);
    exp_mem.push_back({1'b1, base,          w0});
    exp_mem.push_back({1'b1, base + 10'd1,  w1});
    exp_mem.push_back({1'b1, base + 10'd2,  w2});
    exp_mem.push_back({1'b1, base + 10'd3,  w3});
  endtask

  // entered at posedge+1; holds the request until busyClock drops, then
  // lets one more edge complete it
  task automatic access(input logic [9:0] a, input logic rd, input logic wr,
                        input logic [15:0] d, input int exp_busy);
    int n;
    bus.pAddr        = a;
    bus.readRequest  = rd;
    bus.writeRequest = wr;
    bus.pDataOut     = d;
    n = 0;
    @(negedge clk); #2;
    while (bus.busyClock && n < 1000) begin
      n++;
      @(negedge clk); #2;
    end
    chk("busy_cycles", n, exp_busy);
    @(posedge clk); #1;
    bus.readRequest  = 1'b0;
    bus.writeRequest = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    bus.pAddr        = 10'h044;
    bus.pDataOut     = 16'h0;
    bus.readRequest  = 1'b1;  // a request during reset must not stall
    bus.writeRequest = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_busy",   {31'b0, bus.busyClock}, 32'h0);
    chk("rst_mRead",  {31'b0, bus.mRead},     32'h0);
    chk("rst_mWrite", {31'b0, bus.mWrite},    32'h0);
    chk("rst_mAddr",  {22'b0, bus.mAddr},     32'h0);
    @(posedge clk); #1;
    reset           = 1'b1;
    bus.readRequest = 1'b0;

    // clean read miss, then hit in the same line
    push_fill(10'h044); exp_rd.push_back(16'h0044);
    access(10'h044, 1'b1, 1'b0, 16'h0, 5);
    exp_rd.push_back(16'h0046);
    access(10'h046, 1'b1, 1'b0, 16'h0, 0);
    // both requests high acts as a write hit
    access(10'h045, 1'b1, 1'b1, 16'hBEEF, 0);
`ifdef CACHE_STATS_EN
    chk("missCount", {16'b0, missCount}, 32'd1);
    chk("hitCount",  {16'b0, hitCount},  32'd2);
`endif

    // conflict miss on index 17: dirty victim written back first
    push_wb(10'h044, 16'h0044, 16'hBEEF, 16'h0046, 16'h0047);
    push_fill(10'h0C4); exp_rd.push_back(16'h00C4);
    access(10'h0C4, 1'b1, 1'b0, 16'h0, 9);

    // write miss to a clean line: allocate, then the write lands
    push_fill(10'h100);
    access(10'h100, 1'b0, 1'b1, 16'h1234, 5);
    exp_rd.push_back(16'h1234);
    access(10'h100, 1'b1, 1'b0, 16'h0, 0);

    // evict dirty line 0 with slow memory: 1 + 8 words * 4 cycles
    mem_delay = 3;
    push_wb(10'h100, 16'h1234, 16'h0101, 16'h0102, 16'h0103);
    push_fill(10'h000); exp_rd.push_back(16'h0000);
    access(10'h000, 1'b1, 1'b0, 16'h0, 33);
    mem_delay = 0;

    // reset during the second refill word
    exp_mem.push_back({1'b0, 10'h208, 16'h0});
    bus.pAddr       = 10'h208;
    bus.readRequest = 1'b1;
    @(posedge clk);              // miss detected -> FILL
    @(posedge clk); #1;          // word 0 taken
    reset           = 1'b0;
    bus.readRequest = 1'b0;
    @(negedge clk); #2;
    chk("rstfill_mRead_in",  {31'b0, bus.mRead},     32'h0);
    @(posedge clk); #1;
    @(negedge clk); #2;
    chk("rstfill_mRead_out", {31'b0, bus.mRead},     32'h0);
    chk("rstfill_busy",      {31'b0, bus.busyClock}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    push_fill(10'h208); exp_rd.push_back(16'h0208);
    access(10'h208, 1'b1, 1'b0, 16'h0, 5);

    repeat (3) @(posedge clk);
    #1;
    chk("mem_queue_empty", exp_mem.size(), 32'd0);
    chk("rd_queue_empty",  exp_rd.size(),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
